// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per clock, LSB first.
// Each operation takes exactly WIDTH RUN cycles and uses a valid/ready handshake on both sides.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic [2*WIDTH-1:0]    r_acc;
  logic [CW-1:0]         r_cnt;
  logic [2*WIDTH-1:0]    r_product;
  logic [2*WIDTH-1:0]    w_addend;
  logic [2*WIDTH-1:0]    w_sum;
  logic                  w_accept;
  logic                  w_last;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST_BIT);
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // in_ready is masked by rst so nothing can be accepted on a reset edge.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    busy      = (r_state == S_RUN);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Product is only updated here, so it holds across DONE and the following IDLE.
          if (w_last) begin
            r_product <= w_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier (WIDTH=8).
// Expected products come from plain a*b; timing expectations from the handshake rules.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  product;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_q[$];
  int res_q[$];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe handshakes just before each edge takes effect.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) res_q.push_back(int'(product));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, count RUN cycles, hold DONE for 'hold' cycles, handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int hold, input string tag);
    int waited;
    int n_busy;
    int lat;
    logic [31:0] exp_p;
    exp_p = 32'(int'(ta) * int'(tb));
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    out_ready = (hold == 0);
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 32'(waited), 32'(0));
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n_busy = 0;
    lat    = 0;
    while (!out_valid && lat < 100) begin
      if (busy) n_busy++;
      tick();
      lat++;
    end
    $display("op %s: %0d*%0d -> 0x%0h after %0d edges", tag, ta, tb, product, lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(W));
    check({tag, "_product"}, 32'(product), exp_p);
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_hold_product"}, 32'(product), exp_p);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_post_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_post_product"}, 32'(product), exp_p);
    out_ready = 1'b0;
  endtask

  // Run with in_valid and out_ready high until n results are collected.
  task automatic wait_results(input int n, input string tag);
    int guard;
    guard = 0;
    while (res_q.size() < n && guard < 200) begin
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_result_count"}, 32'(res_q.size()), 32'(n));
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_product", 32'(product), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    run_op(8'd255, 8'd255, 0, "max");
    run_op(8'd0, 8'hAB, 0, "zero_a");
    run_op(8'd13, 8'd11, 5, "hold5");

    // Back-to-back: second operands applied right after the first acceptance.
    acc_q.delete(); res_q.delete();
    in_valid = 1'b1; out_ready = 1'b1; a = 8'd3; b = 8'd7;
    while (acc_q.size() < 1 && cyc < 5000) tick();
    a = 8'd12; b = 8'd12;
    wait_results(2, "b2b");
    if (res_q.size() == 2 && acc_q.size() >= 2) begin
      check("b2b_first", 32'(res_q[0]), 32'd21);
      check("b2b_second", 32'(res_q[1]), 32'd144);
      check("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'(W + 2));
      $display("b2b: results %0d %0d, acceptance spacing %0d", res_q[0], res_q[1], acc_q[1] - acc_q[0]);
    end

    // Operands presented during RUN must wait for IDLE.
    acc_q.delete(); res_q.delete();
    in_valid = 1'b1; out_ready = 1'b1; a = 8'd2; b = 8'd9;
    while (acc_q.size() < 1 && cyc < 5000) tick();
    a = 8'd5; b = 8'd5;
    while (res_q.size() < 1 && cyc < 5000) tick();
    check("ignore_run_result", 32'(res_q.size() > 0 ? res_q[0] : -1), 32'd18);
    check("ignore_run_accepts", 32'(acc_q.size()), 32'd1);
    wait_results(2, "ignore_run");
    if (res_q.size() == 2) check("ignore_run_second", 32'(res_q[1]), 32'd25);
    $display("ignore_run: results collected %0d", res_q.size());

    // Reset after 4 RUN cycles.
    in_valid = 1'b1; a = 8'd200; b = 8'd3;
    while (!in_ready && cyc < 5000) tick();
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midrun_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrun_rst_valid", 32'(out_valid), 32'(0));
    check("midrun_rst_product", 32'(product), 32'(0));
    check("midrun_rst_busy", 32'(busy), 32'(0));
    check("midrun_rst_in_ready", 32'(in_ready), 32'(1));
    seen_valid = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check("midrun_no_stale_done", 32'(seen_valid), 32'(0));
    $display("midrun reset: out_valid seen %0d times afterward", seen_valid);

    for (int t = 0; t < 20; t++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1 bit, indicating the operands a and b are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, indicating the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits, the unsigned multiplicand.
REQ-007 The block SHALL have port b, input, WIDTH bits, the unsigned multiplier.
REQ-008 The block SHALL have port out_valid, output, 1 bit, indicating that product holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit, indicating the consumer accepts the result.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits, the registered unsigned product a*b.
REQ-011 The block SHALL have port busy, output, 1 bit, which is high exactly while the state is RUN.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL equal (state==IDLE) and not rst; it is combinational with no dependency on in_valid.
REQ-014 Acceptance SHALL occur on an edge where in_valid and in_ready are both high; on that edge a and b are captured, the accumulator and counter are cleared, and the state goes IDLE->RUN.
REQ-015 In RUN, each edge SHALL process one multiplier bit LSB-first: if the multiplier LSB is 1, the shifted multiplicand is added to the 2*WIDTH-bit accumulator; then the multiplicand shifts left 1, the multiplier shifts right 1, and the counter increments.
REQ-016 The accumulator, shifted multiplicand and sum SHALL each be 2*WIDTH bits wide; overflow is impossible, so no saturation or truncation is needed.
REQ-017 RUN SHALL last exactly WIDTH cycles regardless of operand values, including zero operands (no early exit).
REQ-018 On the edge that processes bit WIDTH-1, the state SHALL go RUN->DONE, the final sum SHALL be written to product, and out_valid SHALL rise; latency is exactly WIDTH edges after the accepting edge.
REQ-019 In DONE, out_valid SHALL stay high and product SHALL stay stable until an edge where out_ready is high; that edge returns the state to IDLE and clears out_valid.
REQ-020 If out_ready is already high on entry to DONE, DONE SHALL last exactly one cycle; the minimum acceptance-to-acceptance period is WIDTH+2 cycles.
REQ-021 After a handshake, product SHALL hold its last value until the next RUN->DONE transition; consumers qualify product with out_valid only.
REQ-022 in_valid, a and b SHALL be ignored in RUN and DONE; there is no pipelining or result bypass.
REQ-023 out_ready SHALL be ignored in IDLE and RUN.

Reset
REQ-024 While rst is high on an edge, the state SHALL become IDLE, and the accumulator, counter, operand registers and product SHALL become 0, and out_valid SHALL become 0, from any state.
REQ-025 While rst is high, in_ready SHALL be 0; in the first cycle after rst falls, in_ready SHALL be 1, busy 0 and out_valid 0.
REQ-026 Reset mid-RUN or mid-DONE SHALL discard the operation with no partial result visible; a new operation may be accepted on the first edge after rst falls.

Verification
REQ-027 The bench SHALL cover: WIDTH=8, a=255, b=255, out_ready=1 -> out_valid rises 8 edges after acceptance with product=0xFE01, and busy is high for 8 cycles.
REQ-028 The bench SHALL cover: a=0, b=0xAB -> product=0x0000, still 8 RUN cycles, and out_valid asserted on schedule.
REQ-029 The bench SHALL cover: a=13, b=11 with out_ready held low for 5 cycles in DONE -> product=143 stable and out_valid high throughout, in_ready low, then IDLE the edge after out_ready rises.
REQ-030 The bench SHALL cover: back-to-back operations 3*7 then 12*12 with in_valid and out_ready tied high -> results 21 then 144, with acceptances 10 cycles apart.
REQ-031 The bench SHALL cover: in_valid high with a=5, b=5 during RUN of 2*9 -> the result is 18 and the second operand pair is not captured until IDLE.
REQ-032 The bench SHALL cover: rst pulsed for one edge after 4 RUN cycles of 200*3 -> next cycle out_valid=0, product=0, busy=0, in_ready=1, and no stale DONE afterward.
